// File: rtl/mpu_matrix_loader.sv
// Byte-stream loader for the 5x5 matrix multiply core: fills matrix A then B,
// then holds the pair under a valid/ready handoff until the consumer takes it.
module mpu_matrix_loader #(
  parameter int DW    = 8,
  parameter int ELEMS = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mats_valid,
  input  logic                  mats_ready,
  output logic [0:DW*ELEMS-1]   matrix_a,
  output logic [0:DW*ELEMS-1]   matrix_b,
  output logic [5:0]            elem_count,
  output logic                  frame_err,
  output logic [1:0]            dbg_state
);

  // Handshakes: a stream beat transfers on a cycle with in_valid & in_ready high;
  // the matrix pair transfers on a cycle with mats_valid & mats_ready high.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_LOAD_B = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  localparam logic [5:0] LAST_A = 6'(ELEMS - 1);
  localparam logic [5:0] LAST_B = 6'(2 * ELEMS - 1);

  state_t               r_state;
  logic [5:0]           r_count;
  logic                 r_in_ready;
  logic                 r_mats_valid;
  logic                 r_frame_err;
  logic [0:DW*ELEMS-1]  r_mat_a;
  logic [0:DW*ELEMS-1]  r_mat_b;

  logic       w_beat;
  logic [5:0] w_slot;
  logic       w_final_b;
  logic       w_last_bad;

  // r_count runs across the whole frame (0..2*ELEMS-1); the B slot is offset by ELEMS.
  assign w_beat     = in_valid & r_in_ready;
  assign w_slot     = (r_state == S_LOAD_B) ? (r_count - 6'(ELEMS)) : r_count;
  assign w_final_b  = (r_state == S_LOAD_B) && (r_count == LAST_B);
  assign w_last_bad = (in_last != w_final_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= 6'd0;
      r_in_ready   <= 1'b0;
      r_mats_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_mat_a      <= '0;
      r_mat_b      <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (flush) begin
        r_state      <= S_LOAD_A;
        r_count      <= 6'd0;
        r_in_ready   <= 1'b1;
        r_mats_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_LOAD_A;
            r_in_ready <= 1'b1;
          end
          S_LOAD_A, S_LOAD_B: begin
            if (w_beat) begin
              if (w_last_bad) begin
                r_state     <= S_LOAD_A;
                r_count     <= 6'd0;
                r_frame_err <= 1'b1;
              end else begin
                if (r_state == S_LOAD_A) r_mat_a[DW*int'(w_slot) +: DW] <= in_data;
                else                     r_mat_b[DW*int'(w_slot) +: DW] <= in_data;
                if (w_final_b) begin
                  r_state      <= S_FULL;
                  r_count      <= 6'd0;
                  r_in_ready   <= 1'b0;
                  r_mats_valid <= 1'b1;
                end else begin
                  r_count <= r_count + 6'd1;
                  if (r_state == S_LOAD_A && r_count == LAST_A) r_state <= S_LOAD_B;
                end
              end
            end
          end
          S_FULL: begin
            if (mats_ready) begin
              r_state      <= S_LOAD_A;
              r_count      <= 6'd0;
              r_in_ready   <= 1'b1;
              r_mats_valid <= 1'b0;
            end
          end
          default: begin
            r_state    <= S_LOAD_A;
            r_count    <= 6'd0;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign mats_valid = r_mats_valid;
  assign frame_err  = r_frame_err;
  assign matrix_a   = r_mat_a;
  assign matrix_b   = r_mat_b;
  assign elem_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed-plus-random bench for mpu_matrix_loader; expected matrices come from
// per-frame element arrays packed by element index.
module tb_mpu_matrix_loader;

  localparam int DW    = 8;
  localparam int ELEMS = 25;
  localparam int MW    = DW * ELEMS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              mats_valid;
  logic              mats_ready = 1'b0;
  logic [0:MW-1]     matrix_a;
  logic [0:MW-1]     matrix_b;
  logic [5:0]        elem_count;
  logic              frame_err;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_a [ELEMS];
  logic [DW-1:0] exp_b [ELEMS];

  mpu_matrix_loader #(.DW(DW), .ELEMS(ELEMS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mats_valid (mats_valid),
    .mats_ready (mats_ready),
    .matrix_a   (matrix_a),
    .matrix_b   (matrix_b),
    .elem_count (elem_count),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:MW-1] pack(input logic [DW-1:0] e [ELEMS]);
    logic [0:MW-1] r;
    r = '0;
    for (int n = 0; n < ELEMS; n++) r[DW*n +: DW] = e[n];
    return r;
  endfunction

  // Element value carried by frame beat i (0-based): A elements first, then B.
  function automatic logic [DW-1:0] beat_val(input int i);
    return (i < ELEMS) ? exp_a[i] : exp_b[i-ELEMS];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int n = 0; n < ELEMS; n++) begin
      exp_a[n] = DW'($urandom);
      exp_b[n] = DW'($urandom);
    end
  endtask

  task automatic fill_pattern();
    for (int n = 0; n < ELEMS; n++) begin
      exp_a[n] = DW'(n + 1);
      exp_b[n] = (n % 6 == 0) ? DW'(1) : DW'(0);
    end
  endtask

  // Sends beats from..to-1 of the current frame; after each accepted beat the
  // bench expects elem_count to equal the number of beats taken so far.
  task automatic send_beats(input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int g = 0; g < idle; g++) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = beat_val(i);
      in_last  = (i == 2*ELEMS - 1);
      chk("in_ready_before_beat", 256'(in_ready), 256'(1));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i == 2*ELEMS - 1) begin
        chk("elem_count_full", 256'(elem_count), 256'(0));
      end else begin
        chk("elem_count_beat", 256'(elem_count), 256'(i + 1));
        chk("mats_valid_loading", 256'(mats_valid), 256'(0));
      end
    end
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_mats_valid"}, 256'(mats_valid), 256'(1));
    chk({tag, "_in_ready"},   256'(in_ready),   256'(0));
    chk({tag, "_matrix_a"},   256'(matrix_a),   256'(pack(exp_a)));
    chk({tag, "_matrix_b"},   256'(matrix_b),   256'(pack(exp_b)));
  endtask

  task automatic consume(input string tag);
    mats_ready = 1'b1;
    tick();
    mats_ready = 1'b0;
    chk({tag, "_mv_after_take"}, 256'(mats_valid), 256'(0));
    chk({tag, "_rdy_after_take"}, 256'(in_ready), 256'(1));
    chk({tag, "_cnt_after_take"}, 256'(elem_count), 256'(0));
  endtask

  initial begin
    // Reset held across several edges.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   256'(in_ready),   256'(0));
    chk("rst_mats_valid", 256'(mats_valid), 256'(0));
    chk("rst_elem_count", 256'(elem_count), 256'(0));
    chk("rst_frame_err",  256'(frame_err),  256'(0));
    chk("rst_matrix_a",   256'(matrix_a),   256'(0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_in_ready", 256'(in_ready), 256'(1));

    // 1: A = 1..25, B = identity, back-to-back.
    fill_pattern();
    send_beats(0, 2*ELEMS, 1'b0);
    check_full("t1");
    chk("t1_a0",  256'(matrix_a[0 +: 8]),   256'(1));
    chk("t1_a24", 256'(matrix_a[192 +: 8]), 256'(25));

    // 2: consumer stalls while upstream keeps offering beats.
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = DW'($urandom);
      in_last = 1'($urandom);
      tick();
      check_full("t2_stall");
      chk("t2_cnt", 256'(elem_count), 256'(0));
    end
    mats_ready = 1'b1;
    tick();
    mats_ready = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    chk("t2_mv_after_take",  256'(mats_valid), 256'(0));
    chk("t2_rdy_after_take", 256'(in_ready),   256'(1));
    chk("t2_cnt_after_take", 256'(elem_count), 256'(0));

    // 3: in_last asserted early on beat 30.
    fill_random();
    send_beats(0, 29, 1'b1);
    in_valid = 1'b1;
    in_data  = beat_val(29);
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t3_frame_err", 256'(frame_err),  256'(1));
    chk("t3_cnt",       256'(elem_count), 256'(0));
    chk("t3_mv",        256'(mats_valid), 256'(0));
    tick();
    chk("t3_err_pulse", 256'(frame_err), 256'(0));
    fill_random();
    send_beats(0, 2*ELEMS, 1'b1);
    check_full("t3");
    consume("t3");

    // 4: in_last missing on the final beat.
    fill_random();
    send_beats(0, 2*ELEMS - 1, 1'b0);
    in_valid = 1'b1;
    in_data  = beat_val(2*ELEMS - 1);
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t4_frame_err", 256'(frame_err),  256'(1));
    chk("t4_mv",        256'(mats_valid), 256'(0));
    chk("t4_cnt",       256'(elem_count), 256'(0));
    chk("t4_rdy",       256'(in_ready),   256'(1));
    tick();
    chk("t4_err_pulse", 256'(frame_err),  256'(0));
    chk("t4_mv_stays",  256'(mats_valid), 256'(0));
    fill_random();
    send_beats(0, 2*ELEMS, 1'b0);
    check_full("t4");
    consume("t4");

    // 5: flush collides with beat 20.
    fill_random();
    send_beats(0, 19, 1'b0);
    in_valid = 1'b1;
    in_data  = beat_val(19);
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_cnt",       256'(elem_count), 256'(0));
    chk("t5_frame_err", 256'(frame_err),  256'(0));
    chk("t5_rdy",       256'(in_ready),   256'(1));
    fill_random();
    send_beats(0, 2*ELEMS, 1'b1);
    check_full("t5");

    // Flush while full drops the pair unconsumed.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5f_mv",  256'(mats_valid), 256'(0));
    chk("t5f_rdy", 256'(in_ready),   256'(1));
    chk("t5f_err", 256'(frame_err),  256'(0));

    // 6: asynchronous reset in the middle of beat 40.
    fill_random();
    send_beats(0, 39, 1'b1);
    in_valid = 1'b1;
    in_data  = beat_val(39);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", 256'(in_ready),   256'(0));
    chk("t6_rst_mv",  256'(mats_valid), 256'(0));
    chk("t6_rst_cnt", 256'(elem_count), 256'(0));
    chk("t6_rst_err", 256'(frame_err),  256'(0));
    chk("t6_rst_a",   256'(matrix_a),   256'(0));
    chk("t6_rst_b",   256'(matrix_b),   256'(0));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_rdy_released", 256'(in_ready), 256'(0));
    tick();
    tick();
    chk("t6_rdy_second_edge", 256'(in_ready), 256'(1));
    fill_random();
    send_beats(0, 2*ELEMS, 1'b1);
    check_full("t6");
    consume("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
